// File: rtl/lsu_if.sv
// Execute-stage request/response and data-memory bus bundle for the LSU.
// master is the LSU side; slave is the core/memory environment side.
interface lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;

  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_o;
  logic        resp_err_o;

  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport master (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: ALU result in, req/gnt/rvalid bus out,
// extended load data back to writeback as a one-cycle registered pulse.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] cnt_q, cnt_d;

  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]  resp_rd_q, resp_rd_d;

  logic        accept, legal, misal, bad, timeout;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, shifted, ext;

  assign accept  = bus.req_valid_i & (state_q == IDLE);
  assign timeout = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == TIMEOUT_CYCLES - 32'd1);

  // Decode is done on the live request so bad requests can bypass the bus.
  always_comb begin
    legal = 1'b0;
    if (bus.req_we_i) legal = (bus.req_funct3_i inside {3'b000, 3'b001, 3'b010});
    else              legal = (bus.req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = ((bus.req_funct3_i[1:0] == 2'b01) & bus.req_addr_i[0]) |
            ((bus.req_funct3_i[1:0] == 2'b10) & (bus.req_addr_i[1:0] != 2'b00));
    bad   = ~legal | misal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = bad ? RESP : REQ;
      REQ:  if (bus.mem_gnt_i) state_d = WAIT;
      WAIT: if (bus.mem_rvalid_i || timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    if (mem_req) begin
      if (!we_q) mem_be = 4'b1111;
      else begin
        unique case (f3_q[1:0])
          2'b00:   begin mem_be = 4'b0001 << addr_q[1:0]; mem_wdata = {4{wdata_q[7:0]}};  end
          2'b01:   begin mem_be = 4'b0011 << addr_q[1:0]; mem_wdata = {2{wdata_q[15:0]}}; end
          default: begin mem_be = 4'b1111;                mem_wdata = wdata_q;            end
        endcase
      end
    end

    shifted = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
    unique case (f3_q)
      3'b000:  ext = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase

    cnt_d        = (state_q == WAIT) ? cnt_q + 32'd1 : 32'd0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    resp_rd_d    = 5'd0;
    // Rejected requests respond straight from IDLE, before rd_q is loaded.
    if (state_q == IDLE && accept && bad) begin
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b1;
      resp_rd_d    = bus.req_rd_i;
    end else if (state_q == WAIT && bus.mem_rvalid_i) begin
      resp_valid_d = 1'b1;
      resp_err_d   = bus.mem_err_i;
      resp_rdata_d = (bus.mem_err_i | we_q) ? 32'd0 : ext;
      resp_rd_d    = rd_q;
    end else if (state_q == WAIT && timeout) begin
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b1;
      resp_rd_d    = rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rd_q         <= 5'd0;
      cnt_q        <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_rd_q    <= 5'd0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we_i;
        f3_q    <= bus.req_funct3_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        rd_q    <= bus.req_rd_i;
      end
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_rd_o    = resp_rd_q;
  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_be_o     = mem_be;
  assign bus.mem_wdata_o  = mem_wdata;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected responses are queued at issue time and
// matched (value and arrival cycle) whenever resp_valid_o is seen.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bif();
  lsu #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc_n      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any response present there.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    if (bif.resp_valid_o === 1'b1) begin
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_resp: observed rd %0d with nothing outstanding at cycle %0d", bif.resp_rd_o, cyc_n);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_rd",    32'(bif.resp_rd_o),  32'(e.rd));
        chk("resp_rdata", bif.resp_rdata_o,    e.rdata);
        chk("resp_err",   32'(bif.resp_err_o), 32'(e.err));
        chk("resp_cycle", 32'(cyc_n),          32'(e.at));
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input bit push);
    chk("req_ready", 32'(bif.req_ready_o), 32'd1);
    bif.req_valid_i  = 1'b1;
    bif.req_we_i     = we;
    bif.req_funct3_i = f3;
    bif.req_addr_i   = addr;
    bif.req_wdata_i  = wd;
    bif.req_rd_i     = rd;
    if (push) sb.push_back('{rd, exp_rdata, exp_err, cyc_n + lat});
    cyc();
    bif.req_valid_i = 1'b0;
  endtask

  // Memory side of one access: grant after gd cycles (rvalid noise meanwhile), data after rvd.
  task automatic mem_txn(input logic [31:0] a, input logic [3:0] be, input logic we,
                         input logic [31:0] wd, input int gd, input int rvd,
                         input logic [31:0] rdata, input logic merr);
    for (int i = 0; i <= gd; i++) begin
      chk("mem_req",   32'(bif.mem_req_o), 32'd1);
      chk("mem_addr",  bif.mem_addr_o,     a);
      chk("mem_be",    32'(bif.mem_be_o),  32'(be));
      chk("mem_we",    32'(bif.mem_we_o),  32'(we));
      chk("mem_wdata", bif.mem_wdata_o,    wd);
      bif.mem_gnt_i    = (i == gd);
      bif.mem_rvalid_i = (i != gd);
      bif.mem_rdata_i  = 32'hBAD0_0000;
      cyc();
    end
    bif.mem_gnt_i    = 1'b0;
    bif.mem_rvalid_i = 1'b0;
    chk("mem_req_drop", 32'(bif.mem_req_o), 32'd0);
    repeat (rvd) cyc();
    bif.mem_rvalid_i = 1'b1;
    bif.mem_rdata_i  = rdata;
    bif.mem_err_i    = merr;
    cyc();
    bif.mem_rvalid_i = 1'b0;
    bif.mem_err_i    = 1'b0;
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] mrd,
                        input logic merr, input int gd, input int rvd,
                        input logic [3:0] xbe, input logic [31:0] xwd,
                        input logic [31:0] xrd, input logic xerr);
    issue(we, f3, addr, wd, rd, xrd, xerr, gd + rvd + 3, 1'b1);
    mem_txn({addr[31:2], 2'b00}, xbe, we, xwd, gd, rvd, mrd, merr);
    cyc();
  endtask

  task automatic reject(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    issue(we, f3, addr, 32'hFFFF_FFFF, rd, 32'd0, 1'b1, 1, 1'b1);
    chk("no_mem_req", 32'(bif.mem_req_o), 32'd0);
    cyc();
  endtask

  initial begin
    bif.req_valid_i = 1'b0; bif.req_we_i = 1'b0; bif.req_funct3_i = 3'd0;
    bif.req_addr_i = 32'd0; bif.req_wdata_i = 32'd0; bif.req_rd_i = 5'd0;
    bif.mem_gnt_i = 1'b0; bif.mem_rvalid_i = 1'b0; bif.mem_rdata_i = 32'd0; bif.mem_err_i = 1'b0;

    cyc(); cyc();
    chk("rst_ready",      32'(bif.req_ready_o),  32'd1);
    chk("rst_mem_req",    32'(bif.mem_req_o),    32'd0);
    chk("rst_mem_be",     32'(bif.mem_be_o),     32'd0);
    chk("rst_resp_valid", 32'(bif.resp_valid_o), 32'd0);
    chk("rst_resp_rdata", bif.resp_rdata_o,      32'd0);
    rst = 1'b0;
    cyc();

    // we f3 addr wdata rd | mem rdata err gd rvd | be wdata | rdata err
    access(0, 3'b010, 32'h100, 32'h0,        5'd1, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    access(0, 3'b000, 32'h203, 32'h0,        5'd2, 32'h80FF0000, 0, 0, 0, 4'b1111, 32'h0,        32'hFFFFFF80, 0);
    access(0, 3'b100, 32'h203, 32'h0,        5'd3, 32'h80FF0000, 0, 0, 0, 4'b1111, 32'h0,        32'h00000080, 0);
    access(0, 3'b101, 32'h202, 32'h0,        5'd4, 32'h80FF0000, 0, 0, 0, 4'b1111, 32'h0,        32'h000080FF, 0);
    access(0, 3'b001, 32'h202, 32'h0,        5'd5, 32'h80FF0000, 0, 0, 0, 4'b1111, 32'h0,        32'hFFFF80FF, 0);
    access(1, 3'b000, 32'h007, 32'h12345678, 5'd6, 32'hFFFFFFFF, 0, 0, 0, 4'b1000, 32'h78787878, 32'h0,        0);
    access(1, 3'b001, 32'h006, 32'h0000ABCD, 5'd7, 32'hFFFFFFFF, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0,        0);
    access(1, 3'b010, 32'h008, 32'hCAFEF00D, 5'd8, 32'h0,        0, 0, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
    // Grant withheld 5 cycles, with rvalid noise that must be ignored in REQ.
    access(0, 3'b010, 32'h500, 32'h0,        5'd9, 32'h01020304, 0, 5, 0, 4'b1111, 32'h0,        32'h01020304, 0);
    access(0, 3'b010, 32'h400, 32'h0,       5'd10, 32'h12345678, 1, 0, 0, 4'b1111, 32'h0,        32'h0,        1);
    // rvalid on the last WAIT cycle before the timeout still wins.
    access(0, 3'b010, 32'h600, 32'h0,       5'd11, 32'h55AA55AA, 0, 0, 3, 4'b1111, 32'h0,        32'h55AA55AA, 0);

    reject(0, 3'b001, 32'h101, 5'd12);
    reject(1, 3'b010, 32'h102, 5'd13);
    reject(0, 3'b011, 32'h100, 5'd14);
    reject(1, 3'b100, 32'h100, 5'd15);

    // Timeout: grant, then silence for 4 WAIT cycles.
    issue(0, 3'b010, 32'h700, 32'h0, 5'd16, 32'd0, 1'b1, 6, 1'b1);
    chk("to_mem_req", 32'(bif.mem_req_o), 32'd1);
    bif.mem_gnt_i = 1'b1;
    cyc();
    bif.mem_gnt_i = 1'b0;
    repeat (4) cyc();
    cyc();

    // Reset while WAITing: abandoned, late rvalid ignored.
    issue(0, 3'b010, 32'h800, 32'h0, 5'd17, 32'd0, 1'b0, 0, 1'b0);
    bif.mem_gnt_i = 1'b1;
    cyc();
    bif.mem_gnt_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready",      32'(bif.req_ready_o),  32'd1);
    chk("midrst_mem_req",    32'(bif.mem_req_o),    32'd0);
    chk("midrst_resp_valid", 32'(bif.resp_valid_o), 32'd0);
    cyc();
    rst = 1'b0;
    bif.mem_rvalid_i = 1'b1;
    bif.mem_rdata_i  = 32'hFEEDFACE;
    cyc();
    bif.mem_rvalid_i = 1'b0;
    cyc(); cyc();
    access(0, 3'b010, 32'h900, 32'h0, 5'd18, 32'h0BADCAFE, 0, 0, 0, 4'b1111, 32'h0, 32'h0BADCAFE, 0);

    chk("pending_resp", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
